// File: rtl/clint_timer.sv
// Machine timer/interrupt source: 64-bit mtime/mtimecmp on a word bus, with a prescaled tick.
// Optional msip software-interrupt register is built only when CLINT_MSIP_EN is defined.
module clint_timer #(
  parameter int PRESCALE_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [15:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        timer_int_raw,
  output logic        sw_int_raw
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE_DIV - 1);

  localparam logic [15:0] ADDR_MSIP    = 16'h0000;
  localparam logic [15:0] ADDR_CMP_LO  = 16'h4000;
  localparam logic [15:0] ADDR_CMP_HI  = 16'h4004;
  localparam logic [15:0] ADDR_TIME_LO = 16'hBFF8;
  localparam logic [15:0] ADDR_TIME_HI = 16'hBFFC;

  logic [15:0] r_presc;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_timer_int;
  logic        r_ack;
  logic [31:0] r_rdata;

  logic [15:0] w_addr;
  logic        w_wr;
  logic        w_rd;
  logic        w_tick;
  logic [63:0] w_mtime_inc;
  logic [31:0] w_msip_rd;
  logic [31:0] w_rd_data;

  // Byte lanes are ignored: the window is word-addressed.
  assign w_addr      = bus_addr & 16'hFFFC;
  assign w_wr        = bus_req & bus_we;
  assign w_rd        = bus_req & ~bus_we;
  assign w_tick      = ~halt & (r_presc == PRESC_LAST);
  assign w_mtime_inc = r_mtime + 64'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (!halt) begin
      r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
    end
  end

  // A half write takes priority over the tick; the tick in that cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime <= '0;
    end else if (w_wr && w_addr == ADDR_TIME_LO) begin
      r_mtime[31:0] <= bus_wdata;
    end else if (w_wr && w_addr == ADDR_TIME_HI) begin
      r_mtime[63:32] <= bus_wdata;
    end else if (w_tick) begin
      r_mtime <= w_mtime_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtimecmp <= '1;
    end else if (w_wr && w_addr == ADDR_CMP_LO) begin
      r_mtimecmp[31:0] <= bus_wdata;
    end else if (w_wr && w_addr == ADDR_CMP_HI) begin
      r_mtimecmp[63:32] <= bus_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer_int <= 1'b0;
    end else begin
      r_timer_int <= (r_mtime >= r_mtimecmp);
    end
  end

`ifdef CLINT_MSIP_EN
  logic r_msip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msip <= 1'b0;
    end else if (w_wr && w_addr == ADDR_MSIP) begin
      r_msip <= bus_wdata[0];
    end
  end

  assign w_msip_rd  = {31'd0, r_msip};
  assign sw_int_raw = r_msip;
`else
  assign w_msip_rd  = 32'd0;
  assign sw_int_raw = 1'b0;
`endif

  always_comb begin
    w_rd_data = 32'd0;
    case (w_addr)
      ADDR_MSIP:    w_rd_data = w_msip_rd;
      ADDR_CMP_LO:  w_rd_data = r_mtimecmp[31:0];
      ADDR_CMP_HI:  w_rd_data = r_mtimecmp[63:32];
      ADDR_TIME_LO: w_rd_data = r_mtime[31:0];
      ADDR_TIME_HI: w_rd_data = r_mtime[63:32];
      default:      w_rd_data = 32'd0;
    endcase
  end

  // Every request is acked next cycle; rdata is non-zero only in a read's ack cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= bus_req;
      r_rdata <= w_rd ? w_rd_data : 32'd0;
    end
  end

  assign bus_ack       = r_ack;
  assign bus_rdata     = r_rdata;
  assign timer_int_raw = r_timer_int;

endmodule

// File: doc/clint_timer.md
# clint_timer

Machine-level timer/interrupt source for the core: holds 64-bit `mtime` and `mtimecmp`, exposes them on a simple memory-mapped word bus, and drives `timer_int_raw` into the CSR block, where it is sampled into `mip[7]`. It sits upstream of the CSR register file and alongside the data-memory bus decoder, which forwards CLINT-range accesses here.

## Interface
- `PRESCALE_DIV`, default 1: core clocks per `mtime` increment; legal range is 1..65535.
- `clk` input 1: core clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `halt` input 1: freezes `mtime` and the prescaler while high (debug halt).
- `bus_req` input 1: access request, valid for one cycle per access.
- `bus_we` input 1: 1 = write, 0 = read; qualified by `bus_req`.
- `bus_addr` input 16: byte offset within the CLINT window; bits [1:0] are ignored.
- `bus_wdata` input 32: write data, full-word writes only.
- `bus_rdata` output 32: read data, valid while `bus_ack` is high.
- `bus_ack` output 1: one-cycle completion pulse.
- `timer_int_raw` output 1: registered (`mtime >= mtimecmp`).
- `sw_int_raw` output 1: `msip[0]` (see Configuration).

## Operation
- Register map:
  - 0x0000: `msip`
  - 0x4000: `mtimecmp[31:0]`
  - 0x4004: `mtimecmp[63:32]`
  - 0xBFF8: `mtime[31:0]`
  - 0xBFFC: `mtime[63:32]`
- Unmapped offsets read 0. Writes to unmapped offsets are ignored but still acked.
- Reset values:
  - `mtime` = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, so no interrupt is raised out of reset.
  - Prescaler count = 0; `msip` = 0.
  - `bus_ack` = 0, `bus_rdata` = 0, `timer_int_raw` = 0, `sw_int_raw` = 0.
- Prescaler:
  - The count runs 0..`PRESCALE_DIV`-1 while `halt` is low.
  - `tick` is asserted when count == `PRESCALE_DIV`-1; the count then wraps to 0.
  - With `PRESCALE_DIV` = 1, `tick` is asserted every non-halted cycle.
  - While `halt` is high, the count holds and `tick` = 0.
- `mtime` increments by 1 on `tick`. It is a full 64-bit unsigned counter that wraps 2^64-1 → 0, with carry propagating lo → hi in the same cycle.
- Half-word writes:
  - A write to either `mtime` half replaces that half only.
  - It suppresses the increment for that cycle; the other half keeps its current value.
  - The prescaler is unaffected.
- `mtimecmp` half writes replace that half only. The comparison uses the full 64-bit value after each write, so software must sequence halves to avoid spurious matches.
- Compare is 64-bit unsigned `>=`.
- `timer_int_raw` is level-sensitive: it stays high until `mtimecmp` is raised above `mtime` or `mtime` wraps.

## Timing
- Bus:
  - A `bus_req` in cycle N produces `bus_ack` = 1 in cycle N+1 with `bus_rdata` registered.
  - `bus_rdata` returns the value before any write in cycle N.
  - Back-to-back requests (N, N+1, …) are each acked one cycle later. There is no stall and no backpressure.
- Reads:
  - `bus_rdata` is 0 in every cycle without `bus_ack`.
  - A write's ack cycle also carries `bus_rdata` = 0.
- Write timing: a write in cycle N is architecturally visible at N+1; an `mtime` read in N+1 sees it.
- Interrupt latency:
  - `timer_int_raw` reflects the compare of register values at edge N, registered at edge N+1.
  - Measured from the edge where `mtime` reaches `mtimecmp` to `timer_int_raw` high: 1 cycle.
  - Measured from a `mtimecmp` write cycle: 2 cycles.
- Simultaneous events:
  - Write to `mtime` together with `tick`: the write wins and the tick is lost.
  - Write to `mtimecmp` together with `tick`: both take effect.
- Reset mid-operation: all state returns to reset values asynchronously. An in-flight request is dropped with no ack.

## Configuration
- Macro: `CLINT_MSIP_EN`.
- Defined:
  - `msip` bit 0 is a read/write register at 0x0000; bits [31:1] read 0.
  - `sw_int_raw` = `msip[0]`, registered, 1 cycle after the write.
- Undefined:
  - 0x0000 behaves as unmapped: reads 0, writes are ignored.
  - `sw_int_raw` is tied to 0.
  - No `msip` flop is present.

## Test plan
- Reset, then read 0x4000/0x4004/0xBFF8 → FFFF_FFFF, FFFF_FFFF, and a small count ≥ 0. `timer_int_raw` stays 0 for 1000 cycles.
- `PRESCALE_DIV`=4; write `mtime` lo=0 and hi=0, wait 40 cycles, read lo → 10 ±1. Hold `halt` for 20 cycles → value unchanged.
- Write `mtimecmp` hi=0 then lo=100 with `mtime`=0 and `PRESCALE_DIV`=1 → `timer_int_raw` rises exactly 1 cycle after `mtime` reads 100. Write `mtimecmp` lo=FFFF_FFFF → `timer_int_raw` falls 2 cycles after the write.
- Write `mtime` lo=FFFF_FFFF, hi=0000_0001, then idle 1 cycle → read hi=0000_0002, lo small (carry checked). Write both halves to FFFF_FFFF → the count wraps to 0.
- Back-to-back read 0xBFF8, write 0x1234 to an unmapped offset, read 0x1234 → three consecutive `bus_ack` pulses; the last returns 0.
- With `CLINT_MSIP_EN`: write 1 to 0x0000 → `sw_int_raw` = 1 next cycle, read 0x0000 → 1. Without the macro → `sw_int_raw` = 0 and the read returns 0.
